alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: DEPTH, default 4, instruction-queue entries (power of 2, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 in_valid  input  1  decoder offers an instruction.
REQ-005 in_ready  output  1  queue can accept; high iff count < DEPTH.
REQ-006 in_op  input  2  00 none, 01 addi, 10 add, 11 reserved.
REQ-007 in_rs1, in_rs2, in_rd  input  5 each  source/destination register addresses.
REQ-008 in_imm  input  32  immediate, addi only.
REQ-009 hold  input  1  external stall; no issue while high.
REQ-010 flush  input  1  taken jump/branch; kill all queued and in-flight ALU work.
REQ-011 addi, add  output  1 each  one-hot issue strobes to the ALU; never both high.
REQ-012 src1_addr, src2_addr, rd  output  5 each  issued operand/destination addresses.
REQ-013 imm  output  32  issued immediate.
REQ-014 jump_branch_enable  output  1  ALU completion suppress.
REQ-015 count  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-016 busy  output  1  high when count != 0 or a strobe is high.

Function
REQ-017 Push when in_valid & in_ready & !flush and in_op is 01 or 10; ops 00/11 are accepted (handshake completes) and discarded.
REQ-018 in_ready depends only on registered count; no push when full even if a pop occurs the same cycle.
REQ-019 Queue is FIFO; read/write pointers wrap modulo DEPTH; count = pushes - pops, never exceeds DEPTH or goes below 0.
REQ-020 All issue outputs (addi, add, src1_addr, src2_addr, rd, imm) are registered; at most one instruction issued per cycle.
REQ-021 A bubble drives addi=add=0 and src1_addr=src2_addr=rd=0, imm=0.
REQ-022 Hazard tracking: p1_rd = rd issued in the current cycle (0 if bubble), p2_rd = p1_rd of previous cycle; both shift every cycle, bubbles included.
REQ-023 Head hazard iff (head.rs1 != 0 & head.rs1 == p2_rd & head.rs1 != p1_rd) or (head is add & same test on head.rs2).
REQ-024 A match on p1_rd is not a hazard; the ALU forwards its own previous result.
REQ-025 FSM states IDLE, RUN, BUBBLE; reset to IDLE.
REQ-026 IDLE: outputs bubble; to RUN when count != 0 after the current cycle's push.
REQ-027 RUN: if count=0 -> IDLE with bubble; elif hold -> stay RUN with bubble, no pop; elif hazard -> BUBBLE with bubble, no pop; else pop head, issue it, stay RUN.
REQ-028 BUBBLE: lasts exactly one cycle with bubble outputs, then RUN; the head is re-evaluated in RUN.
REQ-029 Issue latency: an instruction pushed into an empty queue with no hazard or hold has its strobe high 2 cycles after the push edge.
REQ-030 jump_branch_enable equals the flush input combinationally; it is the only combinational input-to-output path.
REQ-031 Flush at edge: queue emptied (count=0, pointers equalised), a same-cycle push is dropped, issue outputs become bubble, p1_rd=p2_rd=0, FSM -> IDLE.
REQ-032 Flush has priority over push, pop, hold and hazard.

Reset
REQ-033 On reset at any cycle, including mid-issue or mid-BUBBLE: count=0, pointers=0, FSM=IDLE, p1_rd=p2_rd=0, all issue outputs 0, busy=0.
REQ-034 in_ready=1 in the cycle after reset deasserts; queue contents need not be cleared.
REQ-035 Reset has priority over flush; jump_branch_enable still follows flush during reset.

Verification
REQ-036 Back-to-back independent: push addi x1,x0,5 then add x2,x3,x4 -> strobes on consecutive cycles, rd 1 then 2, no bubble.
REQ-037 Forwarding distance 1: addi x1,x0,1 then add x2,x1,x1 -> issued consecutively, no bubble (p1 match).
REQ-038 Distance 2: addi x1; addi x5,x0,2; addi x6,x1,3 -> one bubble before the third issue; rs1=0 or rd=0 cases -> no bubble.
REQ-039 Full queue (DEPTH=4, hold=1): 5 pushes offered -> 4 accepted, in_ready=0, count=4; release hold -> drains in order, in_ready re-asserts after first pop.
REQ-040 Flush with count=3 and a strobe high: jump_branch_enable=1 same cycle; next cycle count=0, strobes 0, FSM IDLE; a same-cycle push is lost.
REQ-041 Reset asserted during BUBBLE with count=2 -> next cycle all outputs 0, count=0, in_ready=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// In-order issue controller for a single ALU: buffers decoded addi/add
// instructions in a small FIFO and issues one per cycle, stalling on hazards.
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [4:0]               in_rd,
  input  logic [31:0]              in_imm,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     addi,
  output logic                     add,
  output logic [4:0]               src1_addr,
  output logic [4:0]               src2_addr,
  output logic [4:0]               rd,
  output logic [31:0]              imm,
  output logic                     jump_branch_enable,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_BUBBLE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          r_q_add [DEPTH];
  logic [4:0]    r_q_rs1 [DEPTH];
  logic [4:0]    r_q_rs2 [DEPTH];
  logic [4:0]    r_q_rd  [DEPTH];
  logic [31:0]   r_q_imm [DEPTH];

  logic          r_addi;
  logic          r_add;
  logic [4:0]    r_src1;
  logic [4:0]    r_src2;
  logic [4:0]    r_rd;
  logic [31:0]   r_imm;
  logic [4:0]    r_p2_rd;

  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_head_add;
  logic [4:0]    w_head_rs1;
  logic [4:0]    w_head_rs2;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_imm;
  logic          w_rs1_haz;
  logic          w_rs2_haz;
  logic          w_hazard;

  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = in_valid & w_in_ready & ~flush &
                      ((in_op == 2'b01) | (in_op == 2'b10));

  assign w_head_add = r_q_add[r_rptr];
  assign w_head_rs1 = r_q_rs1[r_rptr];
  assign w_head_rs2 = r_q_rs2[r_rptr];
  assign w_head_rd  = r_q_rd[r_rptr];
  assign w_head_imm = r_q_imm[r_rptr];

  // r_rd is the rd issued this cycle (distance 1, forwarded by the ALU);
  // only a match two issues back must stall.
  assign w_rs1_haz = (w_head_rs1 != 5'd0) && (w_head_rs1 == r_p2_rd) &&
                     (w_head_rs1 != r_rd);
  assign w_rs2_haz = (w_head_rs2 != 5'd0) && (w_head_rs2 == r_p2_rd) &&
                     (w_head_rs2 != r_rd);
  assign w_hazard  = w_rs1_haz | (w_head_add & w_rs2_haz);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (r_count == '0) begin
          w_state_next = S_IDLE;
        end else if (hold) begin
          w_state_next = S_RUN;
        end else if (w_hazard) begin
          w_state_next = S_BUBBLE;
        end else begin
          w_pop = 1'b1;
        end
      end
      S_BUBBLE: w_state_next = S_RUN;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_add[r_wptr] <= (in_op == 2'b10);
      r_q_rs1[r_wptr] <= in_rs1;
      r_q_rs2[r_wptr] <= in_rs2;
      r_q_rd[r_wptr]  <= in_rd;
      r_q_imm[r_wptr] <= in_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_addi  <= 1'b0;
      r_add   <= 1'b0;
      r_src1  <= 5'd0;
      r_src2  <= 5'd0;
      r_rd    <= 5'd0;
      r_imm   <= 32'd0;
      r_p2_rd <= 5'd0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_addi  <= w_pop & ~w_head_add;
      r_add   <= w_pop & w_head_add;
      r_src1  <= w_pop ? w_head_rs1 : 5'd0;
      r_src2  <= (w_pop & w_head_add) ? w_head_rs2 : 5'd0;
      r_rd    <= w_pop ? w_head_rd : 5'd0;
      r_imm   <= (w_pop & ~w_head_add) ? w_head_imm : 32'd0;
      r_p2_rd <= r_rd;
    end
  end

  assign in_ready           = w_in_ready;
  assign addi               = r_addi;
  assign add                = r_add;
  assign src1_addr          = r_src1;
  assign src2_addr          = r_src2;
  assign rd                 = r_rd;
  assign imm                = r_imm;
  assign jump_branch_enable = flush;
  assign count              = r_count;
  assign busy               = (r_count != '0) | r_addi | r_add;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_alu_issue_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        hold, flush;
  logic        addi, add;
  logic [4:0]  src1_addr, src2_addr, rd;
  logic [31:0] imm;
  logic        jump_branch_enable;
  logic [$clog2(DEPTH):0] count;
  logic        busy;

  alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .hold(hold), .flush(flush), .addi(addi), .add(add),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .rd(rd), .imm(imm),
    .jump_branch_enable(jump_branch_enable), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a plain queue of pending instructions plus the issued slot.
  typedef struct {
    logic        is_add;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
  } instr_t;

  instr_t      mq[$];
  bit          m_run  = 0;
  bit          m_cool = 0;
  logic        m_addi = 0, m_add = 0;
  logic [4:0]  m_s1 = 0, m_s2 = 0, m_rd = 0, m_p2 = 0;
  logic [31:0] m_imm = 0;

  function automatic bit haz(input instr_t h);
    bit a, b;
    a = (h.rs1 != 0) && (h.rs1 == m_p2) && (h.rs1 != m_rd);
    b = (h.rs2 != 0) && (h.rs2 == m_p2) && (h.rs2 != m_rd);
    return a || (h.is_add && b);
  endfunction

  task automatic model_update();
    instr_t h;
    bit iss;
    int n;
    iss = 0;
    h = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0};
    if (reset || flush) begin
      mq.delete();
      m_run = 0; m_cool = 0;
      m_addi = 0; m_add = 0; m_s1 = 0; m_s2 = 0; m_rd = 0; m_imm = 0; m_p2 = 0;
      return;
    end
    n = mq.size();
    if (!m_run) m_run = (n != 0);
    else if (m_cool) m_cool = 0;
    else if (n == 0) m_run = 0;
    else if (!hold) begin
      if (haz(mq[0])) m_cool = 1;
      else begin
        iss = 1;
        h = mq.pop_front();
      end
    end
    if (in_valid && n < DEPTH && (in_op == 2'b01 || in_op == 2'b10))
      mq.push_back('{in_op == 2'b10, in_rs1, in_rs2, in_rd, in_imm});
    m_p2   = m_rd;
    m_addi = iss && !h.is_add;
    m_add  = iss && h.is_add;
    m_s1   = iss ? h.rs1 : 5'd0;
    m_s2   = (iss && h.is_add) ? h.rs2 : 5'd0;
    m_rd   = iss ? h.rd : 5'd0;
    m_imm  = (iss && !h.is_add) ? h.imm : 32'd0;
  endtask

  task automatic step();
    chk("jbe", jump_branch_enable, flush);
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    chk("m_addi", addi, m_addi);
    chk("m_add", add, m_add);
    chk("m_src1", src1_addr, m_s1);
    chk("m_src2", src2_addr, m_s2);
    chk("m_rd", rd, m_rd);
    chk("m_imm", imm, m_imm);
    chk("m_count", count, mq.size());
    chk("m_in_ready", in_ready, mq.size() < DEPTH);
    chk("m_busy", busy, (mq.size() != 0) || m_addi || m_add);
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d, input logic [31:0] im);
    in_valid = v; in_op = op; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_imm = im;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [4:0]  rs1, rs2, rdi;
    logic [31:0] im;
    logic        e_addi, e_add;
    logic [4:0]  e_rd, e_s1, e_s2;
    logic [31:0] e_imm;
    int          e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic v, input logic [1:0] op, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d, input logic [31:0] im,
                         input logic ea, input logic ed, input logic [4:0] erd,
                         input logic [4:0] es1, input logic [4:0] es2,
                         input logic [31:0] eim, input int ecnt);
    vq.push_back('{v, op, s1, s2, d, im, ea, ed, erd, es1, es2, eim, ecnt});
  endtask

  // Pushes three addi ops (rd a, rd 5, rd 6 with rs1 = rs1c) and returns the
  // cycle gap between the issue of rd 5 and rd 6.
  task automatic seq3(input logic [4:0] rda, input logic [4:0] rs1c, output int gap);
    int t5, t6;
    t5 = -1; t6 = -1;
    set_in(1'b1, 2'b01, 5'd0, 5'd0, rda, 32'd1);  step();
    set_in(1'b1, 2'b01, 5'd0, 5'd0, 5'd5, 32'd2); step();
    set_in(1'b1, 2'b01, rs1c, 5'd0, 5'd6, 32'd3); step();
    set_in(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (addi && rd == 5'd5 && t5 < 0) t5 = cyc;
      if (addi && rd == 5'd6 && t6 < 0) t6 = cyc;
      step();
    end
    gap = (t5 < 0 || t6 < 0) ? -1 : t6 - t5;
  endtask

  initial begin
    int gap;
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    set_in(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    step(); step();
    chk("rst_strobes", {addi, add}, 2'b00);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1'b1);

    // Back-to-back independent ops, then distance-1 forwarding, then reserved/none ops.
    add_vec(1, 2'b01, 0, 0, 1, 5,  0, 0, 0, 0, 0, 0, 1);
    add_vec(1, 2'b10, 3, 4, 2, 0,  0, 0, 0, 0, 0, 0, 2);
    add_vec(0, 2'b00, 0, 0, 0, 0,  1, 0, 1, 0, 0, 5, 1);
    add_vec(0, 2'b00, 0, 0, 0, 0,  0, 1, 2, 3, 4, 0, 0);
    add_vec(0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 2'b01, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1);
    add_vec(1, 2'b10, 1, 1, 2, 0,  0, 0, 0, 0, 0, 0, 2);
    add_vec(0, 2'b00, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 1);
    add_vec(0, 2'b00, 0, 0, 0, 0,  0, 1, 2, 1, 1, 0, 0);
    add_vec(0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 2'b11, 1, 2, 9, 7,  0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 2'b00, 1, 2, 9, 7,  0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].v, vq[i].op, vq[i].rs1, vq[i].rs2, vq[i].rdi, vq[i].im);
      step();
      chk($sformatf("vec%0d_addi", i), addi, vq[i].e_addi);
      chk($sformatf("vec%0d_add", i), add, vq[i].e_add);
      chk($sformatf("vec%0d_rd", i), rd, vq[i].e_rd);
      chk($sformatf("vec%0d_src1", i), src1_addr, vq[i].e_s1);
      chk($sformatf("vec%0d_src2", i), src2_addr, vq[i].e_s2);
      chk($sformatf("vec%0d_imm", i), imm, vq[i].e_imm);
      chk($sformatf("vec%0d_count", i), count, vq[i].e_cnt);
    end
    idle(3);

    // Distance-2 dependency stalls for BUBBLE plus re-evaluation; rs1=0 does not.
    seq3(5'd1, 5'd1, gap);
    chk("dist2_gap", gap, 3);
    idle(3);
    seq3(5'd0, 5'd0, gap);
    chk("rd0_gap", gap, 1);
    idle(3);

    // Full queue under hold, then in-order drain.
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 2'b01, 5'd0, 5'd0, 5'(11 + i), 32'(i));
      step();
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 1'b0);
    hold = 1'b0;
    set_in(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    chk("drain0_rd", rd, 5'd11);
    chk("drain0_in_ready", in_ready, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("drain%0d_rd", i), rd, 5'(11 + i));
      chk($sformatf("drain%0d_addi", i), addi, 1'b1);
    end
    step();
    chk("drain_end_busy", busy, 1'b0);
    idle(2);

    // Flush with three queued and a strobe high; the same-cycle push is lost.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'b01, 5'd0, 5'd0, 5'(21 + i), 32'(i));
      step();
    end
    hold = 1'b0;
    set_in(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    chk("pre_flush_count", count, 3);
    chk("pre_flush_addi", addi, 1'b1);
    flush = 1'b1;
    set_in(1'b1, 2'b01, 5'd0, 5'd0, 5'd30, 32'd9);
    #1;
    chk("flush_jbe", jump_branch_enable, 1'b1);
    step();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_strobes", {addi, add}, 2'b00);
    idle(3);
    chk("flush_push_lost", count, 0);
    chk("flush_no_issue", rd, 5'd0);

    // Reset while in BUBBLE with two entries queued.
    set_in(1'b1, 2'b01, 5'd0, 5'd0, 5'd1, 32'd1); step();
    set_in(1'b1, 2'b01, 5'd0, 5'd0, 5'd5, 32'd2); step();
    set_in(1'b1, 2'b01, 5'd1, 5'd0, 5'd6, 32'd3); step();
    set_in(1'b1, 2'b01, 5'd0, 5'd0, 5'd7, 32'd4); step();
    set_in(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0); step();
    chk("bub_count", count, 2);
    chk("bub_strobes", {addi, add}, 2'b00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("bubrst_count", count, 0);
    chk("bubrst_in_ready", in_ready, 1'b1);
    chk("bubrst_outs", {addi, add, src1_addr, src2_addr, rd, busy}, 0);
    chk("bubrst_imm", imm, 32'd0);
    idle(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(59) == 0);
      flush = ($urandom_range(24) == 0);
      hold  = ($urandom_range(4) == 0);
      set_in($urandom_range(9) < 6, 2'($urandom_range(3)), 5'($urandom_range(7)),
             5'($urandom_range(7)), 5'($urandom_range(7)), $urandom);
      step();
    end
    reset = 1'b0; flush = 1'b0; hold = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
